pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
//  Merges per-stage stall requests into the stall[5:0] vector consumed by every
//  pipeline register, including mem_wb. Sequences multi-cycle EX operations (div,
//  madd/msub) with a countdown FSM. Provides a stall watchdog and a stall-cycle
//  performance counter.
// PARAMETERS
//  MC_LEN_W    6     width of ex_mc_len (max multi-cycle length 2^MC_LEN_W-1)
//  WDOG_LIMIT  1024  consecutive stall[0] cycles that set wdog_err
//  WDOG_W      11    watchdog counter width (must hold WDOG_LIMIT)
//  CNT_W       32    width of stall_cycles
// PORTS
//  clk           in   1         pipeline clock, rising edge
//  rst           in   1         asynchronous, active-high reset
//  stallreq_if   in   1         IF stage stall request
//  stallreq_id   in   1         ID stage stall request
//  stallreq_ex   in   1         EX stage stall request (external)
//  stallreq_mem  in   1         MEM stage stall request
//  flush         in   1         exception/flush request; overrides all stalls
//  ex_mc_start   in   1         EX issues a multi-cycle op this cycle
//  ex_mc_len     in   MC_LEN_W  busy length of the op in cycles (0 treated as 1)
//  perf_clr      in   1         synchronous clear of stall_cycles
//  stall         out  6         bit0 PC .. bit5 WB; 1 = hold stage
//  ex_mc_busy    out  1         sequencer in BUSY
//  ex_mc_done    out  1         multi-cycle result valid (DONE state)
//  wdog_err      out  1         sticky: stall held WDOG_LIMIT cycles
//  stall_cycles  out  CNT_W     count of cycles with stall[0]=1, saturating
// BEHAVIOUR
//  Reset (async, rst=1): FSM=IDLE, cnt=0, ex_mc_busy=0, ex_mc_done=0, wdog_err=0,
//   wdog counter=0, stall_cycles=0; stall forced to 6'b000000 while rst=1.
//  stall is combinational (zero latency) from inputs and registered state:
//   flush=1 -> 000000; else stallreq_mem -> 011111; else ex_req -> 001111;
//   else stallreq_id -> 000111; else stallreq_if -> 000011; else 000000.
//   ex_req = stallreq_ex | (state==IDLE & ex_mc_start) | (state==BUSY).
//  FSM IDLE/BUSY/DONE:
//   IDLE: ex_mc_start -> BUSY, cnt <= max(ex_mc_len,1).
//   BUSY: cnt decrements every cycle regardless of downstream stalls;
//     cnt==1 -> DONE. ex_mc_start while BUSY/DONE is ignored.
//   DONE: ex_mc_done=1, no EX stall from sequencer; stallreq_mem=1 -> stay in
//     DONE (result held); else -> IDLE next cycle.
//   Total EX stall for an op of length L with no other requests: L+1 cycles
//     (start cycle + L BUSY cycles), then one DONE cycle.
//   flush=1 in any state -> IDLE, cnt=0 next edge; no done pulse produced;
//     flush and ex_mc_start in same cycle: flush wins, start dropped.
//  Watchdog: counter increments each cycle stall[0]=1, clears when stall[0]=0;
//   reaching WDOG_LIMIT sets wdog_err (sticky until rst); counter saturates.
//  stall_cycles: +1 each cycle stall[0]=1; saturates at all-ones; perf_clr
//   clears to 0 and wins over a simultaneous increment.
//  Outputs ex_mc_busy, ex_mc_done, wdog_err, stall_cycles are registered/state-decoded.
// TESTING
//  Priority: stallreq_if=id=ex=mem=1 -> stall=011111; drop mem -> 001111;
//   drop ex -> 000111; drop id -> 000011; flush=1 with all set -> 000000.
//  ex_mc_start, ex_mc_len=4 -> stall=001111 for 5 cycles, ex_mc_busy 4 cycles,
//   then ex_mc_done=1 for 1 cycle, stall=000000, FSM back to IDLE.
//  ex_mc_len=0 -> treated as 1: 2 stall cycles then one DONE cycle.
//  DONE with stallreq_mem=1 for 3 cycles -> ex_mc_done held 3 cycles + 1 after release.
//  flush during BUSY (cnt=2) -> next cycle IDLE, busy=0, no ex_mc_done ever.
//  WDOG_LIMIT=8: stallreq_id held 8 cycles -> wdog_err=1, stays 1 after release;
//   stall_cycles=8; perf_clr with stall active -> stall_cycles=0.
//  rst asserted mid-BUSY -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall request / stall vector bundle for the pipeline sequencer
// Master drives the per-stage requests; the stall controller is the slave.
interface pipe_stall_ctrl_if #(
  parameter int MC_LEN_W = 6,
  parameter int CNT_W    = 32
);
  logic                stallreq_if;
  logic                stallreq_id;
  logic                stallreq_ex;
  logic                stallreq_mem;
  logic                flush;
  logic                ex_mc_start;
  logic [MC_LEN_W-1:0] ex_mc_len;
  logic                perf_clr;
  logic [5:0]          stall;
  logic                ex_mc_busy;
  logic                ex_mc_done;
  logic                wdog_err;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush,
           ex_mc_start, ex_mc_len, perf_clr,
    input  stall, ex_mc_busy, ex_mc_done, wdog_err, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush,
           ex_mc_start, ex_mc_len, perf_clr,
    output stall, ex_mc_busy, ex_mc_done, wdog_err, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for the 6-stage pipeline
// Merges stage stall requests, sequences multi-cycle EX ops, watchdogs long stalls.
module pipe_stall_ctrl #(
  parameter int MC_LEN_W   = 6,
  parameter int WDOG_LIMIT = 1024,
  parameter int WDOG_W     = 11,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stall_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WDOG_W-1:0]   LP_WDOG_LIM = WDOG_W'(WDOG_LIMIT);
  localparam logic [MC_LEN_W-1:0] LP_ONE      = MC_LEN_W'(1);
  localparam logic [CNT_W-1:0]    LP_CNT_MAX  = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MC_LEN_W-1:0] r_cnt;
  logic [MC_LEN_W-1:0] w_cnt_nxt;
  logic                w_ex_req;
  logic [5:0]          w_stall;
  logic [WDOG_W-1:0]   r_wdog_cnt;
  logic [WDOG_W-1:0]   w_wdog_nxt;
  logic                r_wdog_err;
  logic [CNT_W-1:0]    r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Flush overrides every state and drops a same-cycle start.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.ex_mc_start) begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = (bus.ex_mc_len == '0) ? LP_ONE : bus.ex_mc_len;
          end
        end
        ST_BUSY: begin
          if (r_cnt <= LP_ONE) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - LP_ONE;
          end
        end
        ST_DONE: begin
          if (!bus.stallreq_mem) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_ex_req = bus.stallreq_ex
             | ((r_state == ST_IDLE) & bus.ex_mc_start)
             | (r_state == ST_BUSY);
    w_stall  = 6'b000000;
    if (rst || bus.flush) begin
      w_stall = 6'b000000;
    end else if (bus.stallreq_mem) begin
      w_stall = 6'b011111;
    end else if (w_ex_req) begin
      w_stall = 6'b001111;
    end else if (bus.stallreq_id) begin
      w_stall = 6'b000111;
    end else if (bus.stallreq_if) begin
      w_stall = 6'b000011;
    end
  end

  // Watchdog run length saturates at the limit so the width only needs to hold it.
  always_comb begin
    w_wdog_nxt = '0;
    if (w_stall[0]) begin
      w_wdog_nxt = (r_wdog_cnt == LP_WDOG_LIM) ? r_wdog_cnt : r_wdog_cnt + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt     <= '0;
      r_wdog_err     <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_wdog_cnt <= w_wdog_nxt;
      r_wdog_err <= r_wdog_err | (w_wdog_nxt == LP_WDOG_LIM);
      if (bus.perf_clr) begin
        r_stall_cycles <= '0;
      end else if (w_stall[0] && (r_stall_cycles != LP_CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.ex_mc_busy   = (r_state == ST_BUSY);
  assign bus.ex_mc_done   = (r_state == ST_DONE);
  assign bus.wdog_err     = r_wdog_err;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and random checks of pipe_stall_ctrl
// Reference model tracks remaining busy cycles, done hold, stall run length and counts.
module tb_pipe_stall_ctrl;

  localparam int MC_LEN_W = 6;
  localparam int WLIM     = 8;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  int   m_busy_left;
  bit   m_done;
  int   m_run;
  bit   m_err;
  int   m_sc;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.MC_LEN_W(MC_LEN_W), .CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .MC_LEN_W   (MC_LEN_W),
    .WDOG_LIMIT (WLIM),
    .WDOG_W     (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_stall();
    bit ex_req;
    ex_req = bus.stallreq_ex || (m_busy_left > 0)
          || (m_busy_left == 0 && !m_done && bus.ex_mc_start);
    if (rst || bus.flush)  return 6'b000000;
    if (bus.stallreq_mem)  return 6'b011111;
    if (ex_req)            return 6'b001111;
    if (bus.stallreq_id)   return 6'b000111;
    if (bus.stallreq_if)   return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_busy_left = 0;
    m_done      = 0;
    m_run       = 0;
    m_err       = 0;
    m_sc        = 0;
  endtask

  task automatic model_step();
    logic [5:0] s;
    s = m_stall();
    if (rst) begin
      model_reset();
      return;
    end
    m_run = s[0] ? ((m_run < WLIM) ? m_run + 1 : WLIM) : 0;
    if (m_run >= WLIM) m_err = 1;
    if (bus.perf_clr)                 m_sc = 0;
    else if (s[0] && m_sc < CNT_MAX)  m_sc = m_sc + 1;
    if (bus.flush) begin
      m_busy_left = 0;
      m_done      = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left = m_busy_left - 1;
      if (m_busy_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = bus.stallreq_mem;
    end else if (bus.ex_mc_start) begin
      m_busy_left = (bus.ex_mc_len == 0) ? 1 : int'(bus.ex_mc_len);
    end
  endtask

  task automatic cycle();
    #1;
    chk("stall",        32'(bus.stall),        32'(m_stall()));
    chk("ex_mc_busy",   32'(bus.ex_mc_busy),   32'(m_busy_left > 0));
    chk("ex_mc_done",   32'(bus.ex_mc_done),   32'(m_done));
    chk("wdog_err",     32'(bus.wdog_err),     32'(m_err));
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_sc));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.stallreq_if  = 0;
    bus.stallreq_id  = 0;
    bus.stallreq_ex  = 0;
    bus.stallreq_mem = 0;
    bus.flush        = 0;
    bus.ex_mc_start  = 0;
    bus.ex_mc_len    = '0;
    bus.perf_clr     = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int sc, bc, dc;
    clear_inputs();
    bus.stallreq_mem = 1;
    rst = 1;
    model_reset();
    @(posedge clk);
    #2;
    chk("rst_stall_forced", 32'(bus.stall), 32'h0);
    chk("rst_busy",         32'(bus.ex_mc_busy), 32'h0);
    chk("rst_done",         32'(bus.ex_mc_done), 32'h0);
    chk("rst_wdog",         32'(bus.wdog_err), 32'h0);
    chk("rst_sc",           32'(bus.stall_cycles), 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    clear_inputs();

    // Priority ladder
    bus.stallreq_if = 1; bus.stallreq_id = 1; bus.stallreq_ex = 1; bus.stallreq_mem = 1;
    #1 chk("prio_mem", 32'(bus.stall), 32'h1f);
    cycle();
    bus.stallreq_mem = 0;
    #1 chk("prio_ex", 32'(bus.stall), 32'h0f);
    cycle();
    bus.stallreq_ex = 0;
    #1 chk("prio_id", 32'(bus.stall), 32'h07);
    cycle();
    bus.stallreq_id = 0;
    #1 chk("prio_if", 32'(bus.stall), 32'h03);
    cycle();
    bus.stallreq_id = 1; bus.stallreq_ex = 1; bus.stallreq_mem = 1; bus.flush = 1;
    #1 chk("prio_flush", 32'(bus.stall), 32'h00);
    cycle();
    clear_inputs();
    cycle();

    // Multi-cycle op, length 4
    sc = 0; bc = 0; dc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.ex_mc_start = (i == 0);
      bus.ex_mc_len   = 6'd4;
      #1;
      sc += (bus.stall == 6'b001111);
      bc += bus.ex_mc_busy;
      dc += bus.ex_mc_done;
      cycle();
    end
    chk("len4_stall_cycles", 32'(sc), 32'd5);
    chk("len4_busy_cycles",  32'(bc), 32'd4);
    chk("len4_done_cycles",  32'(dc), 32'd1);

    // Length 0 treated as 1
    sc = 0; dc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.ex_mc_start = (i == 0);
      bus.ex_mc_len   = 6'd0;
      #1;
      sc += (bus.stall == 6'b001111);
      dc += bus.ex_mc_done;
      cycle();
    end
    chk("len0_stall_cycles", 32'(sc), 32'd2);
    chk("len0_done_cycles",  32'(dc), 32'd1);

    // DONE held by MEM stall
    bus.ex_mc_len = 6'd2;
    for (int i = 0; i < 3; i++) begin
      bus.ex_mc_start = (i == 0);
      cycle();
    end
    bus.ex_mc_start = 0;
    dc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.stallreq_mem = (i < 3);
      #1 dc += bus.ex_mc_done;
      cycle();
    end
    chk("done_hold_cycles", 32'(dc), 32'd4);

    // Flush during BUSY with cnt=2
    bus.ex_mc_len = 6'd4;
    for (int i = 0; i < 3; i++) begin
      bus.ex_mc_start = (i == 0);
      cycle();
    end
    bus.ex_mc_start = 0;
    bus.flush = 1;
    cycle();
    bus.flush = 0;
    #1 chk("flush_busy_cleared", 32'(bus.ex_mc_busy), 32'h0);
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      #1 dc += bus.ex_mc_done;
      cycle();
    end
    chk("flush_no_done", 32'(dc), 32'd0);

    // Watchdog and performance counter
    clear_inputs();
    do_reset();
    bus.stallreq_id = 1;
    for (int i = 0; i < WLIM - 1; i++) cycle();
    chk("wdog_before_limit", 32'(bus.wdog_err), 32'h0);
    cycle();
    chk("wdog_at_limit", 32'(bus.wdog_err), 32'h1);
    chk("sc_after_8", 32'(bus.stall_cycles), 32'd8);
    bus.stallreq_id = 0;
    cycle();
    cycle();
    chk("wdog_sticky", 32'(bus.wdog_err), 32'h1);
    bus.stallreq_id = 1;
    bus.perf_clr = 1;
    cycle();
    chk("perf_clr_wins", 32'(bus.stall_cycles), 32'd0);
    bus.perf_clr = 0;
    for (int i = 0; i < CNT_MAX + 6; i++) cycle();
    chk("sc_saturate", 32'(bus.stall_cycles), CNT_MAX);
    bus.stallreq_id = 0;
    cycle();

    // Async reset mid-BUSY
    bus.ex_mc_len = 6'd10;
    for (int i = 0; i < 3; i++) begin
      bus.ex_mc_start = (i == 0);
      cycle();
    end
    bus.ex_mc_start = 0;
    bus.stallreq_mem = 1;
    #1 chk("pre_rst_busy", 32'(bus.ex_mc_busy), 32'h1);
    #1 rst = 1;
    #1;
    chk("async_rst_busy",  32'(bus.ex_mc_busy),   32'h0);
    chk("async_rst_stall", 32'(bus.stall),        32'h0);
    chk("async_rst_wdog",  32'(bus.wdog_err),     32'h0);
    chk("async_rst_sc",    32'(bus.stall_cycles), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    clear_inputs();
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.stallreq_if  = ($urandom % 4) == 0;
      bus.stallreq_id  = ($urandom % 5) == 0;
      bus.stallreq_ex  = ($urandom % 6) == 0;
      bus.stallreq_mem = ($urandom % 5) == 0;
      bus.flush        = ($urandom % 25) == 0;
      bus.ex_mc_start  = ($urandom % 3) == 0;
      bus.ex_mc_len    = MC_LEN_W'($urandom % 8);
      bus.perf_clr     = ($urandom % 40) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
